// File: rtl/framebuffer_row_tx_pkg.sv
// Opcode constants and FSM state encoding for the row readback transmitter.
// READBACK_CHECKSUM_EN adds the CSUM state.
package framebuffer_row_tx_pkg;

    localparam logic [7:0] CMD_ROW_LOAD = 8'h4C;
    localparam logic [7:0] CMD_EOL      = 8'h0A;

    typedef enum logic [3:0] {
        StIdle,
        StHdr,
        StRowb,
        StFetch,
        StWait,
        StData,
        StEol,
        StFin
`ifdef READBACK_CHECKSUM_EN
        , StCsum
`endif
    } state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte serialiser, LSB first, idle high. tx_ready is also high in the
// final tick of the stop bit so a load there chains the next start bit with no gap.
module uart_byte_tx #(
    parameter int unsigned UART_TICKS_PER_BIT = 65,
    parameter int unsigned UART_TICKS_WIDTH   = 7
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       load,
    output logic       tx_ready,
    output logic       tx_out
);

    localparam logic [UART_TICKS_WIDTH-1:0] LAST_TICK = UART_TICKS_WIDTH'(UART_TICKS_PER_BIT - 1);
    localparam logic [3:0]                  STOP_BIT  = 4'd9;

    logic                        active_q, active_d;
    logic [UART_TICKS_WIDTH-1:0] tick_q, tick_d;
    logic [3:0]                  bit_q, bit_d;
    logic [8:0]                  shreg_q, shreg_d;
    logic                        line_q, line_d;
    logic                        last_tick;

    assign last_tick = (tick_q == LAST_TICK);
    assign tx_ready  = !active_q || (last_tick && (bit_q == STOP_BIT));
    assign tx_out    = line_q;

    always_comb begin
        active_d = active_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        line_d   = line_q;
        if (load && tx_ready) begin
            active_d = 1'b1;
            tick_d   = '0;
            bit_d    = '0;
            shreg_d  = {1'b1, data};
            line_d   = 1'b0;
        end else if (active_q) begin
            if (last_tick) begin
                tick_d = '0;
                if (bit_q == STOP_BIT) begin
                    active_d = 1'b0;
                end else begin
                    // Shifting in ones makes the stop bit fall out after the data.
                    bit_d   = bit_q + 4'd1;
                    line_d  = shreg_q[0];
                    shreg_d = {1'b1, shreg_q[8:1]};
                end
            end else begin
                tick_d = tick_q + UART_TICKS_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '1;
            line_q   <= 1'b1;
        end else begin
            active_q <= active_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            line_q   <= line_d;
        end
    end

endmodule

// File: rtl/framebuffer_row_tx.sv
// Reads one framebuffer row from RAM and sends it as an 'L', row, data..., LF frame over UART.
// READBACK_CHECKSUM_EN inserts an XOR checksum byte (row byte and data bytes) before the LF.
module framebuffer_row_tx
    import framebuffer_row_tx_pkg::*;
#(
    parameter int unsigned UART_TICKS_PER_BIT = 65,
    parameter int unsigned UART_TICKS_WIDTH   = 7,
    parameter int unsigned BYTES_PER_ROW      = 128,
    parameter int unsigned ROW_WIDTH          = 5,
    parameter int unsigned ADDR_WIDTH         = 12
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROW_WIDTH-1:0]  row,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_clk_enable,
    input  logic [7:0]            ram_data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  tx_out
);

    localparam logic [7:0] LAST_IDX = 8'(BYTES_PER_ROW - 1);

    state_e               state_q, state_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [7:0]           idx_q, idx_d;
    logic [7:0]           byte_q, byte_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tx_load;
    logic                 tx_ready;
    logic [7:0]           tx_data;
`ifdef READBACK_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    assign ram_address = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(BYTES_PER_ROW) + ADDR_WIDTH'(idx_q);
    assign busy        = busy_q;
    assign done        = done_q;

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        idx_d          = idx_q;
        byte_d         = byte_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        tx_load        = 1'b0;
        tx_data        = CMD_ROW_LOAD;
        ram_clk_enable = 1'b0;
`ifdef READBACK_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    row_d   = row;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StHdr;
`ifdef READBACK_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            StHdr: begin
                tx_data = CMD_ROW_LOAD;
                if (tx_ready) begin
                    tx_load = 1'b1;
                    state_d = StRowb;
                end
            end
            StRowb: begin
                tx_data = 8'(row_q);
                if (tx_ready) begin
                    tx_load = 1'b1;
                    state_d = StFetch;
`ifdef READBACK_CHECKSUM_EN
                    csum_d  = csum_q ^ tx_data;
`endif
                end
            end
            // Fetch and capture run while the previous byte is still on the line.
            StFetch: begin
                ram_clk_enable = 1'b1;
                state_d        = StWait;
            end
            StWait: begin
                byte_d  = ram_data_in;
                state_d = StData;
            end
            StData: begin
                tx_data = byte_q;
                if (tx_ready) begin
                    tx_load = 1'b1;
                    idx_d   = idx_q + 8'd1;
`ifdef READBACK_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_q;
                    state_d = (idx_q == LAST_IDX) ? StCsum : StFetch;
`else
                    state_d = (idx_q == LAST_IDX) ? StEol : StFetch;
`endif
                end
            end
`ifdef READBACK_CHECKSUM_EN
            StCsum: begin
                tx_data = csum_q;
                if (tx_ready) begin
                    tx_load = 1'b1;
                    state_d = StEol;
                end
            end
`endif
            StEol: begin
                tx_data = CMD_EOL;
                if (tx_ready) begin
                    tx_load = 1'b1;
                    state_d = StFin;
                end
            end
            // tx_ready here means the LF stop bit is in its last tick.
            StFin: begin
                if (tx_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef READBACK_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    uart_byte_tx #(
        .UART_TICKS_PER_BIT (UART_TICKS_PER_BIT),
        .UART_TICKS_WIDTH   (UART_TICKS_WIDTH)
    ) u_uart_byte_tx (
        .clk_in   (clk_in),
        .reset    (reset),
        .data     (tx_data),
        .load     (tx_load),
        .tx_ready (tx_ready),
        .tx_out   (tx_out)
    );

endmodule

// File: tb/tb_framebuffer_row_tx.sv
// Bench for framebuffer_row_tx: decodes the UART line and compares each frame with
// a reference frame built from the RAM contents (mem[a] = a[7:0] ^ 8'h5A).
module tb_framebuffer_row_tx;

    localparam int T   = 4;
    localparam int BPR = 4;
`ifdef READBACK_CHECKSUM_EN
    localparam int FRAME_BYTES = BPR + 4;
`else
    localparam int FRAME_BYTES = BPR + 3;
`endif
    localparam int FRAME_CYCLES = FRAME_BYTES * 10 * T + 2;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic [4:0]  row    = '0;
    logic [11:0] ram_address;
    logic        ram_clk_enable;
    logic [7:0]  ram_data_in = 8'hEE;
    logic        busy;
    logic        done;
    logic        tx_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Line monitor state and captured frame.
    bit          mon_active = 1'b0;
    int          mon_t      = 0;
    logic [7:0]  mon_sh     = '0;
    logic [7:0]  rx_q[$];
    int          start_q[$];
    logic [11:0] addr_q[$];
    int          frame_err  = 0;
    int          strobe_cnt = 0;
    int          done_cnt   = 0;
    logic [7:0]  exp_q[$];

    framebuffer_row_tx #(
        .UART_TICKS_PER_BIT (T),
        .UART_TICKS_WIDTH   (7),
        .BYTES_PER_ROW      (BPR),
        .ROW_WIDTH          (5),
        .ADDR_WIDTH         (12)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .start          (start),
        .row            (row),
        .ram_address    (ram_address),
        .ram_clk_enable (ram_clk_enable),
        .ram_data_in    (ram_data_in),
        .busy           (busy),
        .done           (done),
        .tx_out         (tx_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Synchronous-read RAM: data valid only in the cycle after the strobe.
    always @(posedge clk_in)
        ram_data_in <= ram_clk_enable ? (ram_address[7:0] ^ 8'h5A) : 8'hEE;

    always @(negedge clk_in) begin
        int k;
        if (!reset) begin
            mon_active = 1'b0;
        end else begin
            if (ram_clk_enable) begin
                strobe_cnt++;
                addr_q.push_back(ram_address);
            end
            if (done) done_cnt++;
            if (!mon_active) begin
                if (tx_out === 1'b0) begin
                    mon_active = 1'b1;
                    mon_t      = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_t++;
                if (mon_t % T == T / 2) begin
                    k = mon_t / T;
                    if (k >= 1 && k <= 8) begin
                        mon_sh[k-1] = tx_out;
                    end else if (k == 9) begin
                        if (tx_out !== 1'b1) frame_err++;
                        rx_q.push_back(mon_sh);
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    function automatic void build_exp(input int r);
        logic [7:0] x;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'h4C);
        exp_q.push_back(8'(r));
        x = 8'(r);
        for (int k = 0; k < BPR; k++) begin
            b = 8'((r * BPR + k) & 8'hFF) ^ 8'h5A;
            exp_q.push_back(b);
            x ^= b;
        end
`ifdef READBACK_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        exp_q.push_back(8'h0A);
    endfunction

    function automatic bit rx_matches();
        if (rx_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string bytes_str(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic bit gaps_ok();
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != 10 * T) return 1'b0;
        return 1'b1;
    endfunction

    // Launch one frame; optionally pulse start again at cycle c0+mid.
    task automatic run_frame(input logic [4:0] r, input int mid,
                             output int lat, output bit busy_ok, output bit timed_out);
        int c0;
        bit seen;
        rx_q.delete(); start_q.delete(); addr_q.delete();
        strobe_cnt = 0; done_cnt = 0; frame_err = 0;
        @(posedge clk_in); #1;
        start = 1'b1; row = r; c0 = cyc;
        busy_ok = 1'b1; seen = 1'b0; lat = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk_in); #1;
            start = (mid > 0 && cyc == c0 + mid);
            if (start) row = 5'($urandom_range(31));
            @(negedge clk_in);
            if (done) begin
                seen = 1'b1;
                lat  = cyc - c0;
            end else if (busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        start = 1'b0;
        timed_out = !seen;
        repeat (30 * T) @(posedge clk_in);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        n_checks++; if (tx_out !== 1'b1) $display("FAIL reset_tx_out: got %b want 1", tx_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (ram_clk_enable !== 1'b0) $display("FAIL reset_ram_en: got %b want 0", ram_clk_enable); else n_pass++;
        n_checks++; if (ram_address !== 12'h000) $display("FAIL reset_ram_addr: got %h want 000", ram_address); else n_pass++;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++; if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL idle_after_reset: tx_out %b busy %b want 1 0", tx_out, busy); else n_pass++;
    endtask

    task automatic test_frames();
        int lat; bit bok; bit to; logic [4:0] r;
        for (int f = 0; f < 5; f++) begin
            r = (f == 0) ? 5'd0 : (f == 1) ? 5'd31 : 5'($urandom_range(31));
            run_frame(r, 0, lat, bok, to);
            build_exp(r);
            n_checks++; if (to) $display("FAIL frame_timeout row %0d: no done within budget", r); else n_pass++;
            n_checks++; if (!rx_matches()) $display("FAIL frame_bytes row %0d: got %s want %s", r, bytes_str(rx_q), bytes_str(exp_q)); else n_pass++;
            n_checks++; if (lat != FRAME_CYCLES) $display("FAIL frame_latency row %0d: got %0d want %0d", r, lat, FRAME_CYCLES); else n_pass++;
            n_checks++; if (!bok) $display("FAIL frame_busy row %0d: busy dropped before done, want high", r); else n_pass++;
            n_checks++; if (done_cnt != 1) $display("FAIL frame_done_count row %0d: got %0d want 1", r, done_cnt); else n_pass++;
            n_checks++;
            if (addr_q.size() != BPR || addr_q[0] !== 12'(r * BPR) || addr_q[BPR-1] !== 12'(r * BPR + BPR - 1))
                $display("FAIL frame_addresses row %0d: got %0d reads first %h want %0d reads %h..%h",
                         r, addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 12'hxxx, BPR, 12'(r * BPR), 12'(r * BPR + BPR - 1));
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        int lat; bit bok; bit to; logic [4:0] r;
        r = 5'($urandom_range(31));
        // Bit 3 of the first data byte is on the line around c0+99.
        run_frame(r, 99, lat, bok, to);
        build_exp(r);
        n_checks++; if (!rx_matches()) $display("FAIL busy_start_bytes: got %s want %s", bytes_str(rx_q), bytes_str(exp_q)); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (lat != FRAME_CYCLES) $display("FAIL busy_start_latency: got %0d want %0d", lat, FRAME_CYCLES); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int lat; bit bok; bit to; logic [4:0] r;
        r = 5'($urandom_range(31));
        @(posedge clk_in); #1;
        start = 1'b1; row = r;
        @(posedge clk_in); #1;
        start = 1'b0;
        // Now inside the start bit of the second data byte.
        repeat (121) @(posedge clk_in);
        #1;
        n_checks++; if (tx_out !== 1'b0 || busy !== 1'b1) $display("FAIL mid_frame_line: tx_out %b busy %b want 0 1", tx_out, busy); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (tx_out !== 1'b1) $display("FAIL abort_tx_out: got %b want 1", tx_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b1;
        r = 5'($urandom_range(31));
        run_frame(r, 0, lat, bok, to);
        build_exp(r);
        n_checks++; if (!rx_matches()) $display("FAIL after_abort_bytes: got %s want %s", bytes_str(rx_q), bytes_str(exp_q)); else n_pass++;
        n_checks++; if (done_cnt != 1 || to) $display("FAIL after_abort_done: got %0d dones want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_ram_reads();
        int lat; bit bok; bit to;
        run_frame(5'($urandom_range(31)), 0, lat, bok, to);
        n_checks++; if (strobe_cnt != BPR) $display("FAIL ram_strobes: got %0d want %0d", strobe_cnt, BPR); else n_pass++;
        n_checks++; if (frame_err != 0) $display("FAIL stop_bits: got %0d bad stop bits want 0", frame_err); else n_pass++;
        n_checks++; if (start_q.size() != FRAME_BYTES || !gaps_ok())
            $display("FAIL byte_spacing: got %0d starts (spacing ok=%0d) want %0d starts every %0d cycles",
                     start_q.size(), gaps_ok(), FRAME_BYTES, 10 * T);
        else n_pass++;
    endtask

`ifdef READBACK_CHECKSUM_EN
    task automatic test_checksum();
        int lat; bit bok; bit to;
        run_frame(5'd0, 0, lat, bok, to);
        n_checks++; if (rx_q.size() != 8 || rx_q[6] !== 8'h00) $display("FAIL csum_row0: got %s want 4c 00 5a 5b 58 59 00 0a", bytes_str(rx_q)); else n_pass++;
        run_frame(5'd1, 0, lat, bok, to);
        n_checks++; if (rx_q.size() != 8 || rx_q[6] !== 8'h01) $display("FAIL csum_row1: got %s want csum 01 before 0a", bytes_str(rx_q)); else n_pass++;
    endtask
`else
    task automatic test_checksum();
        int lat; bit bok; bit to;
        run_frame(5'd1, 0, lat, bok, to);
        n_checks++; if (rx_q.size() != 7 || rx_q[5] !== 8'h5D) $display("FAIL no_csum_row1: got %s want 4c 01 5e 5f 5c 5d 0a", bytes_str(rx_q)); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_start_while_busy();
        test_reset_mid_frame();
        test_ram_reads();
        test_checksum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
